// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port through one-entry buffers.
// Latency: accepted write reaches the port the next cycle at the earliest, 2 cycles worst case; ready drops only while a buffer is held.
module regfile_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          w_en,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic          busy1,
  output logic          busy2,
  output logic [CW-1:0] conflict_cnt
);

  logic [1:0]    buf_v;
  logic [AW-1:0] buf_addr [2];
  logic [DW-1:0] buf_data [2];
  logic          prio;
  logic          older;

  logic          gnt_vld;
  logic          gnt_idx;
  logic [1:0]    gnt_hit;
  logic [1:0]    acc;
  logic [1:0]    keep;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;

  // Same-register pairs must drain in acceptance order; otherwise alternate fairly.
  always_comb begin
    gnt_vld = |buf_v;
    gnt_idx = 1'b0;
    case (buf_v)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = (buf_addr[0] == buf_addr[1]) ? older : prio;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign gnt_hit    = {gnt_vld & gnt_idx, gnt_vld & ~gnt_idx};
  assign req0_ready = ~buf_v[0] | gnt_hit[0];
  assign req1_ready = ~buf_v[1] | gnt_hit[1];
  assign acc        = {req1_valid & req1_ready, req0_valid & req0_ready};
  assign keep       = buf_v & ~gnt_hit;

  assign gnt_addr = buf_addr[gnt_idx];
  assign gnt_data = buf_data[gnt_idx];

  // Address 0 is hardwired in the register file, so such entries drain without a write.
  assign w_en  = gnt_vld & (gnt_addr != '0) & ~rst;
  assign waddr = w_en ? gnt_addr : '0;
  assign wdata = w_en ? gnt_data : '0;

  assign busy1 = (raddr1 != '0) &&
                 ((buf_v[0] && buf_addr[0] == raddr1) || (buf_v[1] && buf_addr[1] == raddr1));
  assign busy2 = (raddr2 != '0) &&
                 ((buf_v[0] && buf_addr[0] == raddr2) || (buf_v[1] && buf_addr[1] == raddr2));

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v        <= '0;
      buf_addr[0]  <= '0;
      buf_addr[1]  <= '0;
      buf_data[0]  <= '0;
      buf_data[1]  <= '0;
      prio         <= 1'b0;
      older        <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (gnt_vld)
        prio <= ~gnt_idx;

      if (acc[0]) begin
        buf_v[0]    <= 1'b1;
        buf_addr[0] <= req0_addr;
        buf_data[0] <= req0_data;
      end else if (gnt_hit[0]) begin
        buf_v[0] <= 1'b0;
      end

      if (acc[1]) begin
        buf_v[1]    <= 1'b1;
        buf_addr[1] <= req1_addr;
        buf_data[1] <= req1_data;
      end else if (gnt_hit[1]) begin
        buf_v[1] <= 1'b0;
      end

      // Requester 0 is earlier in program order when both arrive together.
      if (acc == 2'b11)
        older <= 1'b0;
      else if (acc[0] && keep[1])
        older <= 1'b1;
      else if (acc[1] && keep[0])
        older <= 1'b0;

      if ((&buf_v) && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
